// File: rtl/pll_lock_rst_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_lock_rst_seq_pkg
// Shared types and helpers for the PLL lock supervisor / reset sequencer.
//   seq_state_e : sequencer FSM state encoding, also exported on state_o
//   timer_w()   : width of the shared state timer, sized from the largest
//                 cycle count any state has to measure
// ---------------------------------------------------------------------------
package pll_lock_rst_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  // The timer counts 0 .. N-1 for the largest N, so clog2(N) bits suffice.
  // A floor of 1 bit keeps degenerate parameter sets elaboratable.
  function automatic int timer_w(input int a, input int b, input int c, input int d);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_if.sv
// ---------------------------------------------------------------------------
// pll_lock_rst_seq_if
// Bundles the sequencer's PLL-facing and domain-facing signals.
//   pll_locked_i    PLL lock flag, asynchronous to the reference clock
//   relock_req_i    1-cycle request to re-reset the PLL (mode change)
//   pll_rst_o       PLL reset, active-high
//   domain_rst_no   per-domain reset requests, active-low
//   ready_o         all domains released and lock held
//   state_o         sequencer state (seq_state_e)
//   lock_loss_cnt_o saturating count of lock drops while releasing/running
//   timeout_cnt_o   saturating count of lock-wait timeouts
// Modports: master = the sequencer, slave = the PLL wrapper / consumers.
// ---------------------------------------------------------------------------
interface pll_lock_rst_seq_if
  import pll_lock_rst_seq_pkg::*;
#(
  parameter int NUM_CLK = 1,
  parameter int CNT_W   = 8
);

  logic               pll_locked_i;
  logic               relock_req_i;
  logic               pll_rst_o;
  logic [NUM_CLK-1:0] domain_rst_no;
  logic               ready_o;
  seq_state_e         state_o;
  logic [CNT_W-1:0]   lock_loss_cnt_o;
  logic [CNT_W-1:0]   timeout_cnt_o;

  modport master (
    input  pll_locked_i, relock_req_i,
    output pll_rst_o, domain_rst_no, ready_o, state_o, lock_loss_cnt_o, timeout_cnt_o
  );

  modport slave (
    output pll_locked_i, relock_req_i,
    input  pll_rst_o, domain_rst_no, ready_o, state_o, lock_loss_cnt_o, timeout_cnt_o
  );

endinterface

// File: rtl/pll_lock_rst_seq_lock_sync_2ff.sv
// ---------------------------------------------------------------------------
// lock_sync_2ff
// Two-flop synchroniser bringing the asynchronous PLL lock flag into the
// reference clock domain. Output lags the input by two clock edges and
// resets to 0 (unlocked) so nothing downstream trusts lock out of reset.
//   clk_i  reference clock
//   rst_ni asynchronous active-low reset
//   d_i    asynchronous input
//   q_o    synchronised output
// ---------------------------------------------------------------------------
module lock_sync_2ff
  import pll_lock_rst_seq_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // p0: metastability capture; p1: settled value
      sync_p0 <= d_i;
      sync_p1 <= sync_p0;
    end
  end

  assign q_o = sync_p1;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// ---------------------------------------------------------------------------
// pll_lock_rst_seq
// PLL lock supervisor and per-domain reset sequencer, clocked from the
// free-running reference clock. Resets the PLL, waits for a debounced lock,
// then releases domain resets one at a time in index order. A lock drop
// while releasing/running re-asserts every domain reset and waits for lock
// again without touching the PLL; a lock-wait timeout or relock request
// re-resets the PLL.
// Ports:
//   clk_i  reference clock (free-running)
//   rst_ni asynchronous active-low reset
//   bus    pll_lock_rst_seq_if.master (lock/relock in, resets/status out)
// Build option:
//   PLL_LOCK_RST_SEQ_STATUS_EN - when defined, lock_loss_cnt_o/timeout_cnt_o
//   are live saturating counters and state_o shows the FSM; otherwise the
//   counter flops are not built and all three outputs are tied to 0.
//   Sequencing is identical either way.
// ---------------------------------------------------------------------------
module pll_lock_rst_seq
  import pll_lock_rst_seq_pkg::*;
#(
  parameter int NUM_CLK             = 1,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W               = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pll_lock_rst_seq_if.master bus
);

  localparam int TW    = timer_w(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                 RELEASE_GAP_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int IDX_W = $clog2(NUM_CLK + 1);

  // Terminal timer values: each state lasts exactly N cycles (timer 0..N-1).
  localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST    = TW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] REL_ALL  = IDX_W'(NUM_CLK);
  localparam logic [IDX_W-1:0] REL_LAST = IDX_W'(NUM_CLK - 1);

  logic               lk;
  seq_state_e         state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IDX_W-1:0]   rel_q, rel_d;     // number of domains released so far
  logic [NUM_CLK-1:0] dom_q, dom_d;     // 1 = domain released
  logic               rdy_q, rdy_d;
  logic               pll_rst_q;
  logic               relock_act;

  lock_sync_2ff u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (bus.pll_locked_i),
    .q_o    (lk)
  );

  // A relock request while the PLL is already in reset changes nothing.
  assign relock_act = bus.relock_req_i && (state_q != RESET_PLL);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rel_d   = rel_q;
    dom_d   = dom_q;
    rdy_d   = rdy_q;

    if (relock_act) begin
      // Wins over a simultaneous lock drop.
      state_d = RESET_PLL;
      dom_d   = '0;
      rdy_d   = 1'b0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (timer_q == RST_LAST) state_d = WAIT_LOCK;
          else                     timer_d = timer_q + 1'b1;
        end
        WAIT_LOCK: begin
          if (lk)                        state_d = STABLE;
          else if (timer_q == TOUT_LAST) state_d = RESET_PLL;
          else                           timer_d = timer_q + 1'b1;
        end
        STABLE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
          end else if (timer_q == STABLE_LAST) begin
            state_d  = RELEASE;
            dom_d    = '0;
            dom_d[0] = 1'b1;
            rel_d    = IDX_W'(1);
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RELEASE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            dom_d   = '0;
            rdy_d   = 1'b0;
          end else if (rel_q == REL_ALL) begin
            // Only reachable with a single domain: released on entry.
            state_d = RUN;
            rdy_d   = 1'b1;
          end else if (timer_q == GAP_LAST) begin
            for (int i = 0; i < NUM_CLK; i++) begin
              if (i == int'(rel_q)) dom_d[i] = 1'b1;
            end
            rel_d   = rel_q + 1'b1;
            timer_d = '0;
            // Last domain: ready rises together with its release.
            if (rel_q == REL_LAST) begin
              state_d = RUN;
              rdy_d   = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            dom_d   = '0;
            rdy_d   = 1'b0;
          end
        end
        default: begin
          state_d = RESET_PLL;
          dom_d   = '0;
          rdy_d   = 1'b0;
        end
      endcase
    end

    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RESET_PLL;
      timer_q   <= '0;
      rel_q     <= '0;
      dom_q     <= '0;
      rdy_q     <= 1'b0;
      pll_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      rel_q     <= rel_d;
      dom_q     <= dom_d;
      rdy_q     <= rdy_d;
      pll_rst_q <= (state_d == RESET_PLL);
    end
  end

  assign bus.pll_rst_o     = pll_rst_q;
  assign bus.domain_rst_no = dom_q;
  assign bus.ready_o       = rdy_q;

`ifdef PLL_LOCK_RST_SEQ_STATUS_EN
  logic             loss_evt;
  logic             tout_evt;
  logic [CNT_W-1:0] loss_cnt_q;
  logic [CNT_W-1:0] tout_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign loss_evt = !relock_act && !lk && ((state_q == RELEASE) || (state_q == RUN));
  assign tout_evt = !relock_act && !lk && (state_q == WAIT_LOCK) && (timer_q == TOUT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loss_cnt_q <= '0;
      tout_cnt_q <= '0;
    end else begin
      if (loss_evt) loss_cnt_q <= sat_inc(loss_cnt_q);
      if (tout_evt) tout_cnt_q <= sat_inc(tout_cnt_q);
    end
  end

  assign bus.lock_loss_cnt_o = loss_cnt_q;
  assign bus.timeout_cnt_o   = tout_cnt_q;
  assign bus.state_o         = state_q;
`else
  assign bus.lock_loss_cnt_o = {CNT_W{1'b0}};
  assign bus.timeout_cnt_o   = {CNT_W{1'b0}};
  assign bus.state_o         = RESET_PLL;
`endif

endmodule
